// File: rtl/layer_input_loader_if.sv
// Stream-in / vector-out bundle between an activation source, the loader and the node array.
interface layer_input_loader_if #(
  parameter int N_IN  = 30,
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]      s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [N_IN*WIDTH-1:0] a_flat;
  logic                  vec_valid;
  logic                  vec_ready;
  logic                  err_len;

  modport master (
    output s_data, s_valid, s_last, vec_ready,
    input  s_ready, a_flat, vec_valid, err_len
  );

  modport slave (
    input  s_data, s_valid, s_last, vec_ready,
    output s_ready, a_flat, vec_valid, err_len
  );
endinterface

// File: rtl/layer_input_loader.sv
// Assembles a serial float32 stream into one N_IN-word activation vector, holds it for the
// node tree to settle, then presents it until the consumer acknowledges.
module layer_input_loader #(
  parameter int N_IN   = 30,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst,
  layer_input_loader_if.slave bus
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_IN*WIDTH-1:0] a_flat_q, a_flat_d;
  logic                  vec_valid_q, vec_valid_d;
  logic                  err_len_q, err_len_d;
  logic                  s_ready_q, s_ready_d;
  logic                  xfer_s;

  assign xfer_s = bus.s_valid && s_ready_q;

  // Next-state, vector write and output decode for the fill/settle/present sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_flat_d    = a_flat_q;
    vec_valid_d = vec_valid_q;
    err_len_d   = 1'b0;
    s_ready_d   = s_ready_q;
    case (state_q)
      ST_FILL: begin
        cnt_d = '0;
        if (xfer_s) begin
          // A short vector zeroes every word above the last one received, in the same edge.
          for (int k = 0; k < N_IN; k++) begin
            if (k == int'(idx_q)) begin
              a_flat_d[k*WIDTH +: WIDTH] = bus.s_data;
            end else if (bus.s_last && (k > int'(idx_q))) begin
              a_flat_d[k*WIDTH +: WIDTH] = '0;
            end else begin
              a_flat_d[k*WIDTH +: WIDTH] = a_flat_q[k*WIDTH +: WIDTH];
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (bus.s_last) begin
              state_d   = ST_SETTLE;
              s_ready_d = 1'b0;
            end else begin
              err_len_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (bus.s_last) begin
            idx_d     = '0;
            err_len_d = 1'b1;
            state_d   = ST_SETTLE;
            s_ready_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        cnt_d = '0;
        if (xfer_s && bus.s_last) begin
          state_d   = ST_SETTLE;
          s_ready_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_PRESENT;
          vec_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESENT: begin
        if (bus.vec_ready) begin
          vec_valid_d = 1'b0;
          idx_d       = '0;
          state_d     = ST_FILL;
          s_ready_d   = 1'b1;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      default: begin
        state_d     = ST_FILL;
        idx_d       = '0;
        cnt_d       = '0;
        vec_valid_d = 1'b0;
        s_ready_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any partial vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      cnt_q       <= '0;
      a_flat_q    <= '0;
      vec_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      s_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_flat_q    <= a_flat_d;
      vec_valid_q <= vec_valid_d;
      err_len_q   <= err_len_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.a_flat    = a_flat_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_layer_input_loader.sv
// Directed and randomised-gap checks of the activation vector loader.
module tb_layer_input_loader;
  localparam int N = 30;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  layer_input_loader_if #(.N_IN(N), .WIDTH(W)) bus ();
  layer_input_loader #(.N_IN(N), .WIDTH(W), .SETTLE(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always @(negedge clk) if (bus.err_len === 1'b1) err_cnt++;

  function automatic int first_diff(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    for (int k = 0; k < N; k++) if (a[k*W +: W] !== b[k*W +: W]) return k;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int gap);
    int n;
    bus.s_valid = 1'b0;
    repeat (gap) tick();
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout got s_ready=%b exp 1", bus.s_ready);
    end
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_vec(output int n);
    n = 0;
    while (bus.vec_valid !== 1'b1 && n < 100) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++;
    if (bus.a_flat !== '0 || bus.vec_valid !== 1'b0 || bus.err_len !== 1'b0 || bus.s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_vals got vv=%b err=%b rdy=%b aflat_nz=%b exp 0 0 1 0",
               bus.vec_valid, bus.err_len, bus.s_ready, |bus.a_flat);
    end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_full();
    logic [N*W-1:0] exp;
    int n, e0, d;
    e0 = err_cnt;
    bus.vec_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp[k*W +: W] = 32'h3F80_0000 + 32'(k);
      send_word(32'h3F80_0000 + 32'(k), (k == N-1), 0);
    end
    wait_vec(n);
    tests++; if (n !== 3) begin fails++; $display("FAIL t1_latency got %0d exp 3", n); end
    tests++;
    if (bus.a_flat !== exp) begin
      fails++; d = first_diff(bus.a_flat, exp);
      $display("FAIL t1_aflat word %0d got %h exp %h", d, bus.a_flat[d*W +: W], exp[d*W +: W]);
    end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL t1_noerr got %0d exp 0", err_cnt - e0); end
    tick();
    tests++;
    if (bus.vec_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      fails++; $display("FAIL t1_vv_1cycle got vv=%b rdy=%b exp 0 1", bus.vec_valid, bus.s_ready);
    end
  endtask

  task automatic test_short();
    logic [N*W-1:0] exp;
    int n, e0, d;
    e0 = err_cnt;
    exp = '0;
    for (int k = 0; k < 10; k++) begin
      exp[k*W +: W] = 32'h4000_0000 + 32'(k);
      send_word(32'h4000_0000 + 32'(k), (k == 9), 0);
    end
    tests++; if (bus.err_len !== 1'b1) begin fails++; $display("FAIL t2_err_pulse got %b exp 1", bus.err_len); end
    wait_vec(n);
    tests++; if (n !== 3) begin fails++; $display("FAIL t2_latency got %0d exp 3", n); end
    tests++;
    if (bus.a_flat !== exp) begin
      fails++; d = first_diff(bus.a_flat, exp);
      $display("FAIL t2_aflat word %0d got %h exp %h", d, bus.a_flat[d*W +: W], exp[d*W +: W]);
    end
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL t2_err_count got %0d exp 1", err_cnt - e0); end
    tick();
  endtask

  task automatic test_long();
    logic [N*W-1:0] exp;
    int n, e0, d;
    e0 = err_cnt;
    for (int k = 0; k < 33; k++) begin
      if (k < N) exp[k*W +: W] = 32'hC000_0000 + 32'(k);
      send_word(32'hC000_0000 + 32'(k), (k == 32), 0);
      if (k == 29) begin
        tests++; if (bus.err_len !== 1'b1) begin fails++; $display("FAIL t3_err_at29 got %b exp 1", bus.err_len); end
      end
    end
    wait_vec(n);
    tests++; if (n !== 3) begin fails++; $display("FAIL t3_latency got %0d exp 3", n); end
    tests++;
    if (bus.a_flat !== exp) begin
      fails++; d = first_diff(bus.a_flat, exp);
      $display("FAIL t3_aflat word %0d got %h exp %h", d, bus.a_flat[d*W +: W], exp[d*W +: W]);
    end
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL t3_err_count got %0d exp 1", err_cnt - e0); end
    tick();
  endtask

  task automatic test_hold();
    logic [N*W-1:0] exp;
    int n, bad;
    bus.vec_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp[k*W +: W] = 32'h1234_0000 + 32'(k);
      send_word(32'h1234_0000 + 32'(k), (k == N-1), 0);
    end
    wait_vec(n);
    tests++; if (n !== 3) begin fails++; $display("FAIL t4_latency got %0d exp 3", n); end
    bus.s_data  = 32'hDEAD_BEEF;
    bus.s_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.vec_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.a_flat !== exp) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL t4_hold_stable got %0d bad cycles (vv=%b rdy=%b) exp 0", bad, bus.vec_valid, bus.s_ready);
    end
    bus.s_valid   = 1'b0;
    bus.vec_ready = 1'b1;
    tick();
    tests++;
    if (bus.vec_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.a_flat !== exp) begin
      fails++; $display("FAIL t4_release got vv=%b rdy=%b aflat_ok=%b exp 0 1 1", bus.vec_valid, bus.s_ready, bus.a_flat === exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0] exp;
    logic [31:0] w;
    int n, d;
    bus.vec_ready = 1'b1;
    for (int k = 0; k < 15; k++) send_word(32'h5555_0000 + 32'(k), 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.a_flat !== '0 || bus.vec_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      fails++; $display("FAIL t5_async_rst got vv=%b rdy=%b aflat_nz=%b exp 0 1 0", bus.vec_valid, bus.s_ready, |bus.a_flat);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    for (int k = 0; k < N; k++) begin
      w = (k == 3) ? 32'h7FC0_0001 : (k == 4) ? 32'h8000_0000 : 32'h3F00_0000 + 32'(k);
      exp[k*W +: W] = w;
      send_word(w, (k == N-1), 0);
    end
    wait_vec(n);
    tests++; if (n !== 3) begin fails++; $display("FAIL t5_latency got %0d exp 3", n); end
    tests++;
    if (bus.a_flat !== exp) begin
      fails++; d = first_diff(bus.a_flat, exp);
      $display("FAIL t5_aflat word %0d got %h exp %h", d, bus.a_flat[d*W +: W], exp[d*W +: W]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N*W-1:0] exp;
    logic [31:0] w;
    int n, bad, stall, d;
    for (int v = 0; v < 100; v++) begin
      bus.vec_ready = 1'b0;
      for (int k = 0; k < N; k++) begin
        w = $urandom;
        exp[k*W +: W] = w;
        send_word(w, (k == N-1), int'($urandom_range(0, 2)));
      end
      wait_vec(n);
      tests++; if (n !== 3) begin fails++; $display("FAIL t6_latency vec %0d got %0d exp 3", v, n); end
      tests++;
      if (bus.a_flat !== exp) begin
        fails++; d = first_diff(bus.a_flat, exp);
        $display("FAIL t6_aflat vec %0d word %0d got %h exp %h", v, d, bus.a_flat[d*W +: W], exp[d*W +: W]);
      end
      stall = int'($urandom_range(0, 4));
      bad = 0;
      repeat (stall) begin
        tick();
        if (bus.vec_valid !== 1'b1 || bus.a_flat !== exp) bad++;
      end
      bus.vec_ready = 1'b1;
      tick();
      if (bus.vec_valid !== 1'b0) bad++;
      tests++; if (bad != 0) begin fails++; $display("FAIL t6_present vec %0d got %0d bad cycles exp 0", v, bad); end
    end
    bus.vec_ready = 1'b0;
  endtask

  initial begin
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.vec_ready = 1'b0;
    test_reset();
    test_full();
    test_short();
    test_long();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
